// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: per-channel FSM state
// encoding and default timing values (in clock cycles).
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int unsigned DEF_DEBOUNCE_LIMIT = 32'd1_000_000;
    localparam int unsigned DEF_REPEAT_DELAY   = 32'd500_000;
    localparam int unsigned DEF_REPEAT_PERIOD  = 32'd200_000;

    // True when a non-zero value is representable in an nbits-wide counter.
    function automatic bit fits_counter(input int unsigned value, input int unsigned nbits);
        return (value >= 32'd1) && ((64'(value) >> nbits) == 64'd0);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// Single button channel: two-flop synchronizer, four-state debounce FSM with
// a saturating stability counter, and a one-cycle press strobe.
// Optional auto-repeat of the press strobe is built when BTN_AUTOREPEAT_EN
// is defined; otherwise no repeat logic exists.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned NB_COUNTER     = 32'd20,
    parameter int unsigned DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
    parameter int unsigned REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD  = DEF_REPEAT_PERIOD
)(
    input  logic clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse,
    output logic o_pulse_next
);

    // An out-of-range configuration keeps the channel parked in reset
    // instead of running with a wrapped limit.
    localparam bit C_CFG_OK = fits_counter(DEBOUNCE_LIMIT, NB_COUNTER) &&
                              fits_counter(REPEAT_DELAY,   NB_COUNTER) &&
                              fits_counter(REPEAT_PERIOD,  NB_COUNTER);

    localparam logic [NB_COUNTER-1:0] C_ZERO     = NB_COUNTER'(0);
    localparam logic [NB_COUNTER-1:0] C_ONE      = NB_COUNTER'(1);
    localparam logic [NB_COUNTER-1:0] C_LIMIT_M1 = NB_COUNTER'(DEBOUNCE_LIMIT - 32'd1);

    logic                  r_sync1;
    logic                  r_sync2;
    btn_state_e            r_state;
    btn_state_e            w_state_next;
    logic [NB_COUNTER-1:0] r_cnt;
    logic [NB_COUNTER-1:0] w_cnt_next;
    logic                  w_press_evt;
    logic                  w_rep_fire;
    logic                  w_level_next;
    logic                  w_pulse_next;
    logic                  r_level;
    logic                  r_pulse;

    // Debounce next-state: a change is accepted only after DEBOUNCE_LIMIT
    // consecutive synchronized samples disagree with the accepted level.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_press_evt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_sync2) begin
                    if (C_LIMIT_M1 == C_ZERO) begin
                        w_state_next = ST_PRESSED;
                        w_cnt_next   = C_ZERO;
                        w_press_evt  = 1'b1;
                    end else begin
                        w_state_next = ST_PRESS_WAIT;
                        w_cnt_next   = C_ONE;
                    end
                end else begin
                    w_cnt_next = C_ZERO;
                end
            end
            ST_PRESS_WAIT: begin
                if (r_sync2) begin
                    if (r_cnt >= C_LIMIT_M1) begin
                        w_state_next = ST_PRESSED;
                        w_cnt_next   = C_ZERO;
                        w_press_evt  = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + C_ONE;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = C_ZERO;
                end
            end
            ST_PRESSED: begin
                if (!r_sync2) begin
                    if (C_LIMIT_M1 == C_ZERO) begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = C_ZERO;
                    end else begin
                        w_state_next = ST_RELEASE_WAIT;
                        w_cnt_next   = C_ONE;
                    end
                end else begin
                    w_cnt_next = C_ZERO;
                end
            end
            ST_RELEASE_WAIT: begin
                if (!r_sync2) begin
                    if (r_cnt >= C_LIMIT_M1) begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = C_ZERO;
                    end else begin
                        w_cnt_next = r_cnt + C_ONE;
                    end
                end else begin
                    w_state_next = ST_PRESSED;
                    w_cnt_next   = C_ZERO;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = C_ZERO;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [NB_COUNTER-1:0] C_DELAY_M1  = NB_COUNTER'(REPEAT_DELAY  - 32'd1);
    localparam logic [NB_COUNTER-1:0] C_PERIOD_M1 = NB_COUNTER'(REPEAT_PERIOD - 32'd1);

    logic [NB_COUNTER-1:0] r_rep;
    logic [NB_COUNTER-1:0] w_rep_next;
    logic                  r_rep_armed;
    logic                  w_rep_armed_next;

    // Repeat timer: runs only while the channel stays in PRESSED; first fire
    // after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
    always_comb begin
        w_rep_next       = r_rep;
        w_rep_armed_next = r_rep_armed;
        w_rep_fire       = 1'b0;
        if ((r_state == ST_PRESSED) && (w_state_next == ST_PRESSED)) begin
            if (!r_rep_armed) begin
                if (r_rep >= C_DELAY_M1) begin
                    w_rep_fire       = 1'b1;
                    w_rep_next       = C_ZERO;
                    w_rep_armed_next = 1'b1;
                end else begin
                    w_rep_next = r_rep + C_ONE;
                end
            end else begin
                if (r_rep >= C_PERIOD_M1) begin
                    w_rep_fire = 1'b1;
                    w_rep_next = C_ZERO;
                end else begin
                    w_rep_next = r_rep + C_ONE;
                end
            end
        end else begin
            w_rep_next       = C_ZERO;
            w_rep_armed_next = 1'b0;
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clock) begin
        if (!i_reset || !C_CFG_OK) begin
            r_rep       <= C_ZERO;
            r_rep_armed <= 1'b0;
        end else begin
            r_rep       <= w_rep_next;
            r_rep_armed <= w_rep_armed_next;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    // Output decode from the next state so both outputs leave a flop.
    always_comb begin
        w_level_next = (w_state_next == ST_PRESSED) || (w_state_next == ST_RELEASE_WAIT);
        w_pulse_next = w_press_evt | w_rep_fire;
    end

    // Synchronizer, FSM state, debounce counter and registered outputs.
    always_ff @(posedge clock) begin
        if (!i_reset || !C_CFG_OK) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= ST_IDLE;
            r_cnt   <= C_ZERO;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_level <= w_level_next;
            r_pulse <= w_pulse_next;
        end
    end

    assign o_level      = r_level;
    assign o_pulse      = r_pulse;
    assign o_pulse_next = w_pulse_next;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: NB_BTN independent debounce channels
// plus a strobe flagging two or more simultaneous press pulses.
// Auto-repeat is included when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned NB_BTN         = 32'd4,
    parameter int unsigned NB_COUNTER     = 32'd20,
    parameter int unsigned DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
    parameter int unsigned REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD  = DEF_REPEAT_PERIOD
)(
    input  logic              clock,
    input  logic              i_reset,
    input  logic [NB_BTN-1:0] i_btn,
    output logic [NB_BTN-1:0] o_btn_level,
    output logic [NB_BTN-1:0] o_btn_pulse,
    output logic              o_btn_multi
);

    logic [NB_BTN-1:0] w_pulse_next;
    logic              w_multi_next;
    logic              r_multi;

    generate
        for (genvar g = 0; g < NB_BTN; g++) begin : g_ch
            btn_debounce_ch #(
                .NB_COUNTER     (NB_COUNTER),
                .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_PERIOD  (REPEAT_PERIOD)
            ) u_ch (
                .clock        (clock),
                .i_reset      (i_reset),
                .i_btn        (i_btn[g]),
                .o_level      (o_btn_level[g]),
                .o_pulse      (o_btn_pulse[g]),
                .o_pulse_next (w_pulse_next[g])
            );
        end
    endgenerate

    // Two or more pulses pending: clearing the lowest set bit leaves a bit.
    always_comb begin
        w_multi_next = ((w_pulse_next & (w_pulse_next - NB_BTN'(1))) != '0);
    end

    // Register the multi strobe so it lines up with the channel pulses.
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            r_multi <= 1'b0;
        end else begin
            r_multi <= w_multi_next;
        end
    end

    assign o_btn_multi = r_multi;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with a behavioural reference model.
module tb_btn_conditioner;

    localparam int NB  = 4;
    localparam int DL  = 4;
    localparam int RD  = 8;
    localparam int RP  = 3;

    logic          clock = 1'b0;
    logic          i_reset;
    logic [NB-1:0] i_btn;
    logic [NB-1:0] o_btn_level;
    logic [NB-1:0] o_btn_pulse;
    logic          o_btn_multi;

    always #5 clock = ~clock;

    btn_conditioner #(
        .NB_BTN         (NB),
        .NB_COUNTER     (8),
        .DEBOUNCE_LIMIT (DL),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_btn       (i_btn),
        .o_btn_level (o_btn_level),
        .o_btn_pulse (o_btn_pulse),
        .o_btn_multi (o_btn_multi)
    );

    int checks   = 0;
    int failures = 0;
    bit model_en = 1'b0;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    // Reference model: raw input seen 2 edges late; accepted level flips after
    // DL consecutive disagreeing samples; press acceptance gives a pulse;
    // optional repeat counts edges spent stably pressed.
    int m_d1 [NB];
    int m_d2 [NB];
    int m_lvl[NB];
    int m_run[NB];
    int m_q  [NB];
    int m_s, m_p, m_np;
    bit m_was, m_now;
    logic [NB-1:0] exp_level = '0;
    logic [NB-1:0] exp_pulse = '0;
    logic          exp_multi = 1'b0;

    always @(posedge clock) begin
        if (!i_reset) begin
            for (int c = 0; c < NB; c++) begin
                m_d1[c] = 0; m_d2[c] = 0; m_lvl[c] = 0; m_run[c] = 0; m_q[c] = 0;
            end
            exp_level = '0;
            exp_pulse = '0;
            exp_multi = 1'b0;
        end else begin
            m_np = 0;
            for (int c = 0; c < NB; c++) begin
                m_s     = m_d2[c];
                m_d2[c] = m_d1[c];
                m_d1[c] = int'(i_btn[c]);
                m_was   = (m_lvl[c] == 1) && (m_run[c] == 0);
                m_p     = 0;
                if (m_s != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] >= DL) begin
                        m_lvl[c] = m_s;
                        m_run[c] = 0;
                        if (m_s == 1) m_p = 1;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_now = (m_lvl[c] == 1) && (m_run[c] == 0);
                if (REPEAT_ON) begin
                    if (m_was && m_now) m_q[c]++;
                    else m_q[c] = 0;
                    if (m_q[c] == RD || (m_q[c] > RD && ((m_q[c] - RD) % RP) == 0)) m_p = 1;
                end
                exp_level[c] = (m_lvl[c] == 1);
                exp_pulse[c] = (m_p == 1);
                m_np += m_p;
            end
            exp_multi = (m_np >= 2);
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clock) begin
        if (model_en) begin
            checks++;
            if (o_btn_level !== exp_level) begin
                failures++;
                $display("FAIL model_level t=%0t actual=%b expected=%b", $time, o_btn_level, exp_level);
            end
            checks++;
            if (o_btn_pulse !== exp_pulse) begin
                failures++;
                $display("FAIL model_pulse t=%0t actual=%b expected=%b", $time, o_btn_pulse, exp_pulse);
            end
            checks++;
            if (o_btn_multi !== exp_multi) begin
                failures++;
                $display("FAIL model_multi t=%0t actual=%b expected=%b", $time, o_btn_multi, exp_multi);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic settle(input int n);
        i_btn = '0;
        repeat (n) step();
    endtask

    task automatic wait_pulse(input int max_edges, output int edge_no,
                              output logic [NB-1:0] val, output logic mult);
        edge_no = 0;
        val     = '0;
        mult    = 1'b0;
        for (int e = 1; e <= max_edges; e++) begin
            step();
            if (o_btn_pulse != '0) begin
                edge_no = e;
                val     = o_btn_pulse;
                mult    = o_btn_multi;
                break;
            end
        end
    endtask

    int            t_edge, t_first, t_cnt, t_rel;
    logic [NB-1:0] t_val;
    logic          t_mult;
    bit            t_quiet;
    int            hold;

    initial begin
        i_reset = 1'b0;
        i_btn   = '0;
        step();
        model_en = 1'b1;
        chk("reset_level", int'(o_btn_level), 0);
        chk("reset_pulse", int'(o_btn_pulse), 0);
        chk("reset_multi", int'(o_btn_multi), 0);
        i_reset = 1'b1;
        step();

        // Clean press on channel 0.
        i_btn = 4'b0001; t_first = 0; t_cnt = 0; t_val = '0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (o_btn_pulse != '0) begin
                if (t_first == 0) begin t_first = e; t_val = o_btn_pulse; end
                t_cnt++;
            end
        end
        chk("clean_first_edge", t_first, 6);
        chk("clean_pulse_val", int'(t_val), 1);
        chk("clean_pulse_count", t_cnt, REPEAT_ON ? 4 : 1);
        chk("clean_level_held", int'(o_btn_level), 1);
        i_btn = 4'b0000; t_rel = 0;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (o_btn_level[0] == 1'b0 && t_rel == 0) t_rel = e;
        end
        chk("clean_release_edge", t_rel, 6);

        // Bounce on channel 1.
        t_quiet = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_btn = (k % 2 == 0) ? 4'b0010 : 4'b0000;
            step();
            if (o_btn_pulse != '0 || o_btn_level != '0) t_quiet = 1'b0;
        end
        chk("bounce_quiet", int'(t_quiet), 1);
        i_btn = 4'b0010;
        wait_pulse(15, t_edge, t_val, t_mult);
        chk("bounce_edge", t_edge, 6);
        chk("bounce_val", int'(t_val), 2);
        settle(12);

        // Short glitch on channel 2.
        t_quiet = 1'b1;
        i_btn = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            step();
            if (o_btn_pulse != '0 || o_btn_level != '0) t_quiet = 1'b0;
        end
        i_btn = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            step();
            if (o_btn_pulse != '0 || o_btn_level != '0) t_quiet = 1'b0;
        end
        chk("glitch_quiet", int'(t_quiet), 1);

        // Simultaneous press.
        i_btn = 4'b1010;
        wait_pulse(15, t_edge, t_val, t_mult);
        chk("simul_edge", t_edge, 6);
        chk("simul_val", int'(t_val), 10);
        chk("simul_multi", int'(t_mult), 1);
        step();
        chk("simul_pulse_after", int'(o_btn_pulse), 0);
        chk("simul_multi_after", int'(o_btn_multi), 0);
        settle(12);

        // Reset mid-press with the button held.
        i_btn = 4'b0001; t_quiet = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (o_btn_pulse != '0 || o_btn_level != '0) t_quiet = 1'b0;
        end
        i_reset = 1'b0;
        step();
        i_reset = 1'b1;
        if (o_btn_pulse != '0 || o_btn_level != '0 || o_btn_multi != 1'b0) t_quiet = 1'b0;
        chk("rst_mid_quiet", int'(t_quiet), 1);
        wait_pulse(15, t_edge, t_val, t_mult);
        chk("rst_mid_edge", t_edge, 6);
        chk("rst_mid_val", int'(t_val), 1);
        settle(12);

        // Long hold on channel 3 for auto-repeat.
        i_btn = 4'b1000; t_cnt = 0; t_first = 0;
        for (int e = 1; e <= 29; e++) begin
            step();
            if (o_btn_pulse[3]) begin
                if (t_first == 0) t_first = e;
                t_cnt++;
            end
        end
        chk("repeat_first", t_first, 6);
        chk("repeat_count", t_cnt, REPEAT_ON ? 7 : 1);
        i_btn = 4'b0000; t_cnt = 0;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (o_btn_pulse != '0) t_cnt++;
        end
        chk("repeat_after_release", t_cnt, 0);

        // Randomized segments, checked by the model every cycle.
        for (int n = 0; n < 400; n++) begin
            i_btn = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) hold = int'($urandom_range(15, 40));
            else hold = int'($urandom_range(1, 8));
            for (int h = 0; h < hold; h++) begin
                if ($urandom_range(0, 150) == 0) i_reset = 1'b0;
                else i_reset = 1'b1;
                if ($urandom_range(0, 5) == 0) i_btn[$urandom_range(0, 3)] ^= 1'b1;
                step();
            end
        end
        i_reset = 1'b1;
        settle(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
